// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//   Shares N_WB register-file/ROB writeback ports among N_SRC execution-unit
//   result lanes. Each cycle up to N_WB valid lanes are granted in round-robin
//   order starting at rr_ptr. Losers see src_ready=0 and must hold their result.
//   Granted results appear on the registered wb_* outputs one cycle later.
//
// Ports
//   clk          clock, all state updates on posedge
//   rst          synchronous active-high reset
//   flush        pipeline flush: no grants this cycle, no writeback next cycle
//   src_valid    per-lane "result available"
//   src_ready    per-lane grant (combinational, never without src_valid)
//   src_data     per-lane result data
//   src_dest     per-lane destination physical register
//   src_rob      per-lane ROB index
//   wb_valid     per-port writeback strobe (registered, single-cycle pulse)
//   wb_data      per-port writeback data
//   wb_dest      per-port writeback physical register
//   wb_rob       per-port writeback ROB index
//   conflict_cnt saturating count of cycles with more than N_WB valid lanes
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int N_SRC  = 8,
    parameter int N_WB   = 2,
    parameter int DATA_W = 64,
    parameter int PREG_W = 7,
    parameter int ROB_W  = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [N_SRC-1:0]                 src_valid,
    output logic [N_SRC-1:0]                 src_ready,
    input  logic [N_SRC-1:0][DATA_W-1:0]     src_data,
    input  logic [N_SRC-1:0][PREG_W-1:0]     src_dest,
    input  logic [N_SRC-1:0][ROB_W-1:0]      src_rob,
    output logic [N_WB-1:0]                  wb_valid,
    output logic [N_WB-1:0][DATA_W-1:0]      wb_data,
    output logic [N_WB-1:0][PREG_W-1:0]      wb_dest,
    output logic [N_WB-1:0][ROB_W-1:0]       wb_rob,
    output logic [31:0]                      conflict_cnt
);

    localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [PTR_W-1:0]            rr_ptr;
    logic [PTR_W-1:0]            nxt_ptr;
    logic [N_WB-1:0]             sel_valid;
    logic [N_WB-1:0][PTR_W-1:0]  sel_idx;
    logic [PTR_W-1:0]            scan_idx;
    int                          scan;
    int                          n_grant;
    logic                        too_many;

    assign too_many = $countones(src_valid) > N_WB;

    // Round-robin scan from rr_ptr; the j-th granted lane in scan order
    // drives port j, so ports always fill from 0 upward.
    always_comb begin
        // NOTE: every variable gets a default before any conditional update,
        // otherwise the tool infers latches for paths that skip assignment.
        src_ready = '0;
        sel_valid = '0;
        sel_idx   = '0;
        nxt_ptr   = rr_ptr;
        n_grant   = 0;
        scan      = 0;
        scan_idx  = '0;
        if (!rst && !flush) begin
            for (int s = 0; s < N_SRC; s++) begin
                scan = int'(rr_ptr) + s;
                if (scan >= N_SRC) scan = scan - N_SRC;
                scan_idx = PTR_W'(scan);
                if (src_valid[scan_idx] && n_grant < N_WB) begin
                    src_ready[scan_idx] = 1'b1;
                    for (int k = 0; k < N_WB; k++) begin
                        if (n_grant == k) begin
                            sel_valid[k] = 1'b1;
                            sel_idx[k]   = scan_idx;
                        end
                    end
                    n_grant = n_grant + 1;
                    // Pointer lands just past the last lane granted.
                    nxt_ptr = (scan == N_SRC - 1) ? '0 : PTR_W'(scan + 1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            rr_ptr       <= '0;
            wb_valid     <= '0;
            wb_data      <= '0;
            wb_dest      <= '0;
            wb_rob       <= '0;
            conflict_cnt <= '0;
        end else begin
            // With flush or no grants, nxt_ptr equals rr_ptr and sel_valid is 0.
            rr_ptr   <= nxt_ptr;
            wb_valid <= sel_valid;
            for (int k = 0; k < N_WB; k++) begin
                wb_data[k] <= src_data[sel_idx[k]];
                wb_dest[k] <= src_dest[sel_idx[k]];
                wb_rob[k]  <= src_rob[sel_idx[k]];
            end
            if (too_many && !flush && conflict_cnt != 32'hFFFF_FFFF)
                conflict_cnt <= conflict_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter
//   Directed stimulus for wb_port_arbiter. Each driven cycle checks src_ready
//   immediately and queues the writeback expected one cycle later; a separate
//   monitor pops and compares against wb_* after every posedge.
// ---------------------------------------------------------------------------
module tb_wb_port_arbiter;

    localparam int N_SRC  = 8;
    localparam int N_WB   = 2;
    localparam int DATA_W = 64;
    localparam int PREG_W = 7;
    localparam int ROB_W  = 8;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          flush;
    logic [N_SRC-1:0]              src_valid;
    logic [N_SRC-1:0]              src_ready;
    logic [N_SRC-1:0][DATA_W-1:0]  src_data;
    logic [N_SRC-1:0][PREG_W-1:0]  src_dest;
    logic [N_SRC-1:0][ROB_W-1:0]   src_rob;
    logic [N_WB-1:0]               wb_valid;
    logic [N_WB-1:0][DATA_W-1:0]   wb_data;
    logic [N_WB-1:0][PREG_W-1:0]   wb_dest;
    logic [N_WB-1:0][ROB_W-1:0]    wb_rob;
    logic [31:0]                   conflict_cnt;

    wb_port_arbiter #(
        .N_SRC (N_SRC),
        .N_WB  (N_WB),
        .DATA_W(DATA_W),
        .PREG_W(PREG_W),
        .ROB_W (ROB_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .src_data    (src_data),
        .src_dest    (src_dest),
        .src_rob     (src_rob),
        .wb_valid    (wb_valid),
        .wb_data     (wb_data),
        .wb_dest     (wb_dest),
        .wb_rob      (wb_rob),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N_WB-1:0]              v;
        logic [N_WB-1:0][DATA_W-1:0]  d;
        logic [N_WB-1:0][PREG_W-1:0]  dest;
        logic [N_WB-1:0][ROB_W-1:0]   rob;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic [DATA_W-1:0] d,
                            input logic [PREG_W-1:0] de, input logic [ROB_W-1:0] r);
        src_data[i] = d;
        src_dest[i] = de;
        src_rob[i]  = r;
    endtask

    task automatic default_lanes();
        for (int i = 0; i < N_SRC; i++)
            set_lane(i, 64'hD000 + 64'(i), 7'(16 + i), 8'(64 + i));
    endtask

    // Expected writeback: lane l0 on port 0, lane l1 on port 1 (-1 = idle port).
    function automatic exp_t mk(input int l0, input int l1);
        exp_t e;
        e = '0;
        if (l0 >= 0) begin
            e.v[0] = 1'b1; e.d[0] = src_data[l0]; e.dest[0] = src_dest[l0]; e.rob[0] = src_rob[l0];
        end
        if (l1 >= 0) begin
            e.v[1] = 1'b1; e.d[1] = src_data[l1]; e.dest[1] = src_dest[l1]; e.rob[1] = src_rob[l1];
        end
        return e;
    endfunction

    task automatic step(input logic [N_SRC-1:0] v, input logic fl, input logic [N_SRC-1:0] rdy,
                        input int l0, input int l1, input string tag);
        @(negedge clk);
        src_valid = v;
        flush     = fl;
        #1;
        check({tag, "_ready"}, 64'(src_ready), 64'(rdy));
        exp_q.push_back(mk(l0, l1));
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expected entry per driven cycle, compared after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int k = 0; k < N_WB; k++) begin
                    check($sformatf("wb%0d_valid", k), 64'(wb_valid[k]), 64'(e.v[k]));
                    if (e.v[k]) begin
                        check($sformatf("wb%0d_data", k), wb_data[k], e.d[k]);
                        check($sformatf("wb%0d_dest", k), 64'(wb_dest[k]), 64'(e.dest[k]));
                        check($sformatf("wb%0d_rob", k), 64'(wb_rob[k]), 64'(e.rob[k]));
                    end
                end
            end else begin
                check("idle_wb_valid", 64'(wb_valid), 64'd0);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        src_valid = '0;
        default_lanes();

        // Reset held two cycles with every lane requesting.
        step(8'hFF, 1'b0, 8'h00, -1, -1, "rst0");
        step(8'hFF, 1'b0, 8'h00, -1, -1, "rst1");
        after_edge();
        check("rst_conflict_cnt", 64'(conflict_cnt), 64'd0);
        check("rst_rr_ptr", 64'(dut.rr_ptr), 64'd0);
        rst       = 1'b0;
        src_valid = '0;

        // Single lane 4.
        set_lane(4, 64'hDEAD, 7'd5, 8'd9);
        step(8'h10, 1'b0, 8'h10, 4, -1, "single");
        after_edge();
        check("single_rr_ptr", 64'(dut.rr_ptr), 64'd5);
        check("single_conflict_cnt", 64'(conflict_cnt), 64'd0);
        default_lanes();

        // Lane 7 alone brings the pointer back to 0.
        step(8'h80, 1'b0, 8'h80, 7, -1, "lane7");
        after_edge();
        check("lane7_rr_ptr", 64'(dut.rr_ptr), 64'd0);

        // All lanes valid and held: pairs in order, even lane on port 0.
        step(8'hFF, 1'b0, 8'h03, 0, 1, "all_a");
        step(8'hFF, 1'b0, 8'h0C, 2, 3, "all_b");
        step(8'hFF, 1'b0, 8'h30, 4, 5, "all_c");
        step(8'hFF, 1'b0, 8'hC0, 6, 7, "all_d");
        step(8'hFF, 1'b0, 8'h03, 0, 1, "all_e");
        after_edge();
        check("all_conflict_cnt", 64'(conflict_cnt), 64'd5);
        check("all_rr_ptr", 64'(dut.rr_ptr), 64'd2);

        // Move pointer to 7, then wrap across lanes {7,0,3}.
        step(8'h40, 1'b0, 8'h40, 6, -1, "to7");
        step(8'h89, 1'b0, 8'h81, 7, 0, "wrap");
        after_edge();
        check("wrap_rr_ptr", 64'(dut.rr_ptr), 64'd1);
        step(8'h08, 1'b0, 8'h08, 3, -1, "wrap_tail");
        after_edge();
        check("wrap_tail_rr_ptr", 64'(dut.rr_ptr), 64'd4);
        check("wrap_conflict_cnt", 64'(conflict_cnt), 64'd6);

        // Flush with all lanes valid; lane 3's result still lands that cycle.
        step(8'hFF, 1'b1, 8'h00, -1, -1, "flush");
        after_edge();
        check("flush_rr_ptr", 64'(dut.rr_ptr), 64'd4);
        check("flush_conflict_cnt", 64'(conflict_cnt), 64'd6);
        step(8'hFF, 1'b0, 8'h30, 4, 5, "resume");
        after_edge();
        check("resume_rr_ptr", 64'(dut.rr_ptr), 64'd6);
        check("resume_conflict_cnt", 64'(conflict_cnt), 64'd7);

        // Saturation of the conflict counter.
        force dut.conflict_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.conflict_cnt;
        check("sat_preload", 64'(conflict_cnt), 64'hFFFF_FFFE);
        step(8'hFF, 1'b0, 8'hC0, 6, 7, "sat_a");
        after_edge();
        check("sat_a_conflict_cnt", 64'(conflict_cnt), 64'hFFFF_FFFF);
        step(8'hFF, 1'b0, 8'h03, 0, 1, "sat_b");
        step(8'hFF, 1'b0, 8'h0C, 2, 3, "sat_c");
        after_edge();
        check("sat_c_conflict_cnt", 64'(conflict_cnt), 64'hFFFF_FFFF);
        check("sat_c_rr_ptr", 64'(dut.rr_ptr), 64'd4);

        // Drain: the monitor consumes the last expected entries.
        step(8'h00, 1'b0, 8'h00, -1, -1, "drain");
        repeat (2) @(posedge clk);
        #3;
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
